// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter register and instruction-fetch controller.
// Drives pc to an external adder and takes pc+4 back on pc_inc. Fetches one
// word per req/ack handshake, keeps a one-entry skid buffer for decode
// backpressure, and handles branch/jump redirects.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect -> TRAP_PC + trap pulse).
module pc_fetch_ctrl #(
  parameter int unsigned         ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter logic [ADDR_W-1:0]   TRAP_PC  = 'h100
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] pc_inc,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              trap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   pc_d, addr_d, ipc_d, skid_pc, skid_pc_d, tgt;
  logic [31:0]         instr_d, skid_data, skid_data_d;
  logic                valid_d, trap_d, misaligned, slot_free;

  assign slot_free = !instr_valid || !stall;

  // Redirect target selection
  always_comb begin
    misaligned = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    misaligned = (redirect_pc[1:0] != 2'b00);
    tgt        = misaligned ? TRAP_PC : redirect_pc;
`else
    tgt        = {redirect_pc[ADDR_W-1:2], 2'b00};
`endif
  end

  // Next-state and datapath next values; redirect takes priority over everything
  always_comb begin
    state_d     = state;
    pc_d        = pc;
    addr_d      = imem_addr;
    instr_d     = instr;
    ipc_d       = instr_pc;
    valid_d     = instr_valid && stall;   // drops when decode takes the word
    skid_data_d = skid_data;
    skid_pc_d   = skid_pc;
    trap_d      = 1'b0;
    imem_req    = (state == REQ) || (state == KILL);

    if (redirect) begin
      pc_d    = tgt;
      valid_d = 1'b0;
      trap_d  = misaligned;
      unique case (state)
        REQ: begin
          if (imem_ack) addr_d  = tgt;
          else          state_d = KILL;
        end
        // An unacknowledged request in KILL must stay on the bus; pc already
        // holds the new target and is picked up when the ack arrives.
        KILL: begin
          if (imem_ack) begin
            addr_d  = tgt;
            state_d = REQ;
          end
        end
        default: begin
          addr_d  = tgt;
          state_d = REQ;
        end
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          addr_d  = pc;
          state_d = REQ;
        end
        REQ: begin
          if (imem_ack) begin
            pc_d = pc_inc;
            if (slot_free) begin
              instr_d = imem_rdata;
              ipc_d   = imem_addr;
              valid_d = 1'b1;
              addr_d  = pc_inc;
            end else begin
              skid_data_d = imem_rdata;
              skid_pc_d   = imem_addr;
              state_d     = HOLD;
            end
          end
        end
        HOLD: begin
          if (slot_free) begin
            instr_d = skid_data;
            ipc_d   = skid_pc;
            valid_d = 1'b1;
            addr_d  = pc;
            state_d = REQ;
          end
        end
        KILL: begin
          if (imem_ack) begin
            addr_d  = pc;
            state_d = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_addr   <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      trap        <= 1'b0;
      skid_data   <= '0;
      skid_pc     <= '0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      imem_addr   <= addr_d;
      instr       <= instr_d;
      instr_pc    <= ipc_d;
      instr_valid <= valid_d;
      trap        <= trap_d;
      skid_data   <= skid_data_d;
      skid_pc     <= skid_pc_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed and random checks of pc_fetch_ctrl against a
// stream-level model: delivered instructions must be the memory words of a
// consecutive +4 address sequence restarted at each redirect target.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TRP_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, pc_inc, redirect_pc, imem_addr, imem_rdata, instr, instr_pc;
  logic        stall, redirect, imem_req, imem_ack, instr_valid, trap;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] exp_tgt(input logic [31:0] r);
`ifdef PC_MISALIGN_TRAP_EN
    return (r[1:0] != 2'b00) ? TRP_PC : r;
`else
    return {r[31:2], 2'b00};
`endif
  endfunction

  function automatic logic exp_mis(input logic [31:0] r);
`ifdef PC_MISALIGN_TRAP_EN
    return r[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  assign pc_inc     = pc + 32'd4;
  assign imem_rdata = memf(imem_addr);

  pc_fetch_ctrl #(.ADDR_W(32), .RESET_PC(RST_PC), .TRAP_PC(TRP_PC)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_inc(pc_inc), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .trap(trap)
  );

  int          checks = 0;
  int          errors = 0;
  int          n_cons = 0;
  logic [31:0] exp_next;
  logic        prev_pending, exp_vzero, exp_trap;
  logic [31:0] prev_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_next     = RST_PC;
    prev_pending = 1'b0;
    exp_vzero    = 1'b0;
    exp_trap     = 1'b0;
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic step(input logic st, input logic ak, input logic rd, input logic [31:0] rpc);
    if (prev_pending) begin
      chk("req_held", {31'b0, imem_req}, 32'd1);
      chk("addr_held", imem_addr, prev_addr);
    end
    if (exp_vzero) chk("valid_after_redirect", {31'b0, instr_valid}, 32'd0);
    chk("trap", {31'b0, trap}, {31'b0, exp_trap});
    stall       = st;
    imem_ack    = ak;
    redirect    = rd;
    redirect_pc = rpc;
    if (instr_valid && !st) begin
      chk("instr_pc", instr_pc, exp_next);
      chk("instr", instr, memf(exp_next));
      exp_next = exp_next + 32'd4;
      n_cons++;
    end
    prev_pending = imem_req && !ak;
    prev_addr    = imem_addr;
    exp_vzero    = rd;
    exp_trap     = rd && exp_mis(rpc);
    if (rd) exp_next = exp_tgt(rpc);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] held, r;
    int          base;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_pc", pc, RST_PC);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_trap", {31'b0, trap}, 32'd0);

    // Release: first request after edge 1, first instruction after edge 2
    rst_n = 1'b1;
    step(0, 1, 0, 0);
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RST_PC);
    chk("first_valid", {31'b0, instr_valid}, 32'd0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("stream_valid", {31'b0, instr_valid}, 32'd1);
      chk("stream_pc", instr_pc, 32'(4 * i));
      step(0, 1, 0, 0);
    end

    // Stall with acks: word held, one in skid, requests stop
    held = instr_pc;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      chk("stall_hold_pc", instr_pc, held);
      chk("stall_hold_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_no_req", {31'b0, imem_req}, 32'd0);
    end
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);

    // Redirect while a request is outstanding and unacknowledged
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h40);
    chk("kill_pc", pc, 32'h40);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("kill_newaddr", imem_addr, 32'h40);
    chk("kill_valid", {31'b0, instr_valid}, 32'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);

    // Redirect on the same cycle as ack with decode stalled
    chk("pre80_valid", {31'b0, instr_valid}, 32'd1);
    step(1, 1, 1, 32'h80);
    chk("r80_addr", imem_addr, 32'h80);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);

    // Address wrap
    step(0, 1, 1, 32'hFFFF_FFFC);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step(0, 1, 0, 0);
    chk("wrap_addr1", imem_addr, 32'h0);
    chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0);

    // Misaligned redirect
    step(0, 1, 1, 32'h42);
    chk("mis_pc", pc, exp_tgt(32'h42));
    chk("mis_addr", imem_addr, exp_tgt(32'h42));
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);

    // Asynchronous reset in the middle of a request
    step(0, 0, 0, 0);
    chk("pre_rst_req", {31'b0, imem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_req", {31'b0, imem_req}, 32'd0);
    chk("async_valid", {31'b0, instr_valid}, 32'd0);
    chk("async_pc", pc, RST_PC);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    base = n_cons;
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
    chk("refetch_count", 32'(n_cons - base), 32'd4);

    // Random traffic
    base = n_cons;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom;
      if ($urandom_range(3) != 0) r[1:0] = 2'b00;
      step(($urandom_range(9) < 3), ($urandom_range(9) < 6), ($urandom_range(19) == 0), r);
    end
    chk("random_progress", {31'b0, (n_cons - base) > 150}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
